// File: rtl/div_unit_if.sv
// Handshake/operand bundle between control (master) and the multicycle divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_unsigned;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, is_unsigned, dividend, divisor,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, is_unsigned, dividend, divisor,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider: remainder to HI, quotient to LO, one quotient bit per clock.
// Optional macro DIV_UNSIGNED_EN enables divu semantics through is_unsigned.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic     clock,
  input logic     reset,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             qneg_reg;
  logic             rneg_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dz_reg;

  logic             use_sign;
  logic             sd;
  logic             ss;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shift_val;
  logic [WIDTH:0]   diff_val;

`ifdef DIV_UNSIGNED_EN
  assign use_sign = ~bus.is_unsigned;
`else
  logic unused_is_unsigned;
  assign unused_is_unsigned = bus.is_unsigned;
  assign use_sign = 1'b1;
`endif

  assign sd      = use_sign & bus.dividend[WIDTH-1];
  assign ss      = use_sign & bus.divisor[WIDTH-1];
  // The most negative value negates to itself, which is the correct unsigned magnitude.
  assign dvd_mag = sd ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_mag = ss ? (~bus.divisor + 1'b1) : bus.divisor;

  assign shift_val = {rem_reg, quo_reg[WIDTH-1]};
  assign diff_val  = shift_val - {1'b0, dvs_reg};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      cnt_reg   <= '0;
      qneg_reg  <= 1'b0;
      rneg_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              done_reg <= 1'b1;
              dz_reg   <= 1'b1;
            end else begin
              quo_reg   <= dvd_mag;
              dvs_reg   <= dvs_mag;
              rem_reg   <= '0;
              qneg_reg  <= sd ^ ss;
              rneg_reg  <= sd;
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          // Top bit of the widened difference is the borrow: set means restore.
          if (!diff_val[WIDTH]) begin
            rem_reg <= diff_val[WIDTH-1:0];
          end else begin
            rem_reg <= shift_val[WIDTH-1:0];
          end
          quo_reg <= {quo_reg[WIDTH-2:0], ~diff_val[WIDTH]};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          lo_reg    <= qneg_reg ? (~quo_reg + 1'b1) : quo_reg;
          hi_reg    <= rneg_reg ? (~rem_reg + 1'b1) : rem_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.div_zero = dz_reg;
  assign bus.hi_out   = hi_reg;
  assign bus.lo_out   = lo_reg;

endmodule
